// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the seven-segment scan controller:
//     - state_e        : scan FSM state encoding (IDLE / BLANK / SHOW)
//     - NUM_DIGITS     : number of multiplexed digits on the display
//     - anode_inactive : anode bus value with every digit switched off
//     - anode_active   : anode bus value with only one digit lit
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam int NUM_DIGITS = 4;

  // Anode bus value with every digit dark, for either anode polarity.
  function automatic logic [NUM_DIGITS-1:0] anode_inactive(input bit active_low);
    return active_low ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  endfunction

  // Anode bus value with only digit 'sel' lit, for either anode polarity.
  function automatic logic [NUM_DIGITS-1:0] anode_active(input logic [1:0] sel,
                                                          input bit         active_low);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << sel;
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/seg_next_digit.sv
// -----------------------------------------------------------------------------
// seg_next_digit
//   Combinational rotate-priority finder. Searches digits_en for the first set
//   bit strictly after cur_sel (cur_sel+1, +2, +3 modulo 4), falling back to
//   cur_sel itself.
//
//   Ports:
//     cur_sel   in  2  digit currently selected (search starts after it)
//     digits_en in  4  per-digit enable mask
//     next_sel  out 2  next enabled digit index (cur_sel when mask is empty)
//     wrap      out 1  next_sel <= cur_sel, i.e. the scan pass wraps
//     none      out 1  no digit enabled at all
// -----------------------------------------------------------------------------
module seg_next_digit
  import seg_pkg::*;
(
  input  logic [1:0]            cur_sel,
  input  logic [NUM_DIGITS-1:0] digits_en,
  output logic [1:0]            next_sel,
  output logic                  wrap,
  output logic                  none
);

  // Walk the candidates from farthest to nearest so the nearest enabled one
  // is written last and wins. Offset 4 (== 0 modulo 4) is cur_sel itself,
  // the lowest-priority fallback.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every output of an always_comb is given a value before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    next_sel = cur_sel;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      idx = cur_sel + 2'(k);
      if (digits_en[idx]) next_sel = idx;
    end
  end

  assign wrap = (next_sel <= cur_sel);
  assign none = (digits_en == '0);

endmodule

// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   Drives the select of the external 4:1 nibble mux and the matching anode,
//   inserting an all-dark blanking gap around every select change to stop
//   ghosting, and skipping digits whose enable bit is clear.
//
//   Ports:
//     clk        in  1  system clock
//     rst        in  1  synchronous, active-high reset
//     enable     in  1  scanning allowed
//     digits_en  in  4  per-digit display enable (bit i = digit i)
//     dp_in      in  4  decimal point request per digit
//     sel        out 2  select to the external 4:1 nibble mux
//     anode      out 4  digit anodes, polarity per ANODE_ACTIVE_LOW
//     dp_n       out 1  active-low decimal point for the lit digit
//     frame_done out 1  one-cycle pulse when a scan pass wraps
//
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int CLK_DIV          = 50000,  // clocks each digit is lit, >= 1
  parameter int BLANK_CYCLES     = 16,     // dark clocks after a select change, >= 1
  parameter bit ANODE_ACTIVE_LOW = 1'b1    // 1 = anode asserted low
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digits_en,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [1:0]            sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int MAX_CNT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = anode_inactive(ANODE_ACTIVE_LOW);

  state_e                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_done_q, frame_done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [1:0]            finder_cur;
  logic [1:0]            next_sel;
  logic                  next_wrap;
  logic                  none_en;

  // From IDLE the search starts "after digit 3", so the rotate order becomes
  // 0,1,2,3 and the finder yields the lowest enabled index.
  assign finder_cur = (state_q == IDLE) ? 2'd3 : sel_q;

  seg_next_digit u_next_digit (
    .cur_sel   (finder_cur),
    .digits_en (digits_en),
    .next_sel  (next_sel),
    .wrap      (next_wrap),
    .none      (none_en)
  );

  // Outputs default to "dark": the anode is only driven on cycles that stay
  // in (or enter) SHOW, so a select change can never coincide with a lit digit.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    anode_d      = ANODE_OFF;
    dp_n_d       = 1'b1;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && !none_en) begin
          sel_d   = next_sel;
          cnt_d   = '0;
          state_d = BLANK;
        end
      end

      BLANK: begin
        if (!enable || none_en) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          anode_d = anode_active(sel_q, ANODE_ACTIVE_LOW);
          dp_n_d  = ~dp_in[sel_q];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHOW: begin
        if (!enable || none_en) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!digits_en[sel_q] || cnt_q == SHOW_LAST) begin
          // Dwell over (or the lit digit was just disabled): move on.
          sel_d        = next_sel;
          cnt_d        = '0;
          state_d      = BLANK;
          frame_done_d = next_wrap;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          anode_d = anode_active(sel_q, ANODE_ACTIVE_LOW);
          dp_n_d  = ~dp_in[sel_q];
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order within the block.
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      anode_q      <= ANODE_OFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      anode_q      <= anode_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sel        = sel_q;
  assign anode      = anode_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_controller
//   Self-checking bench for seg_scan_controller with CLK_DIV=4, BLANK_CYCLES=2,
//   ANODE_ACTIVE_LOW=1: a vector table, directed corner-case sequences and a
//   randomized run compared against a behavioural model of the scan rules.
// -----------------------------------------------------------------------------
module tb_seg_scan_controller;

  localparam int CLK_DIV = 4;
  localparam int BLANK_N = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] digits_en;
  logic [3:0] dp_in;
  logic [1:0] sel;
  logic [3:0] anode;
  logic       dp_n;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_controller #(
    .CLK_DIV          (CLK_DIV),
    .BLANK_CYCLES     (BLANK_N),
    .ANODE_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits_en  (digits_en),
    .dp_in      (dp_in),
    .sel        (sel),
    .anode      (anode),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: mode 0 = dark/idle, 1 = gap, 2 = lit. 'left' counts the
  // clocks remaining in the current gap or dwell.
  // ---------------------------------------------------------------------------
  int         m_mode = 0;
  int         m_sel  = 0;
  int         m_left = 0;
  bit         m_fd   = 0;
  bit         m_dpn  = 1;

  function automatic int lowest_enabled(input logic [3:0] en);
    for (int i = 0; i < 4; i++) if (en[i]) return i;
    return 0;
  endfunction

  function automatic int next_enabled(input int cur, input logic [3:0] en);
    for (int k = 1; k <= 4; k++) if (en[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  function automatic logic [3:0] model_anode();
    return (m_mode == 2) ? (4'hF & ~(4'(1) << m_sel)) : 4'hF;
  endfunction

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    int nxt;
    if (rst) begin
      m_mode = 0; m_sel = 0; m_left = 0; m_fd = 0; m_dpn = 1;
      return;
    end
    m_fd  = 0;
    m_dpn = 1;
    case (m_mode)
      0: if (enable && digits_en != 0) begin
           m_sel = lowest_enabled(digits_en); m_left = BLANK_N; m_mode = 1;
         end
      1: if (!enable || digits_en == 0) m_mode = 0;
         else begin
           m_left--;
           if (m_left == 0) begin
             m_mode = 2; m_left = CLK_DIV; m_dpn = !dp_in[m_sel];
           end
         end
      default: begin
        if (!enable || digits_en == 0) m_mode = 0;
        else begin
          m_left--;
          if (!digits_en[m_sel] || m_left == 0) begin
            nxt    = next_enabled(m_sel, digits_en);
            m_fd   = (nxt <= m_sel);
            m_sel  = nxt;
            m_mode = 1;
            m_left = BLANK_N;
          end else begin
            m_dpn = !dp_in[m_sel];
          end
        end
      end
    endcase
  endtask

  // One clock: step the model on the pre-edge inputs, then settle past the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic [1:0] e_sel, input logic [3:0] e_an,
                               input logic e_dpn, input logic e_fd, input string tag);
    check({tag, ".sel"},        32'(sel),        32'(e_sel));
    check({tag, ".anode"},      32'(anode),      32'(e_an));
    check({tag, ".dp_n"},       32'(dp_n),       32'(e_dpn));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
  endtask

  // Bounded wait: a timeout becomes a failed comparison.
  task automatic wait_anode(input logic [3:0] tgt, input int budget, input string tag);
    int n = 0;
    while (anode !== tgt && n < budget) begin
      tick();
      n++;
    end
    check({tag, ".wait_anode"}, 32'(anode), 32'(tgt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs applied before an edge, outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] de;
    logic [3:0] dp;
    logic [1:0] e_sel;
    logic [3:0] e_an;
    logic       e_dpn;
    logic       e_fd;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int fd_cycles[$];
    int cyc;
    bit bad_anode;

    rst = 1'b1; enable = 1'b0; digits_en = 4'hF; dp_in = 4'h0;

    //            rst en  de       dp       sel an     dpn fd
    vecs[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0, 4'hF, 1'b1, 1'b0}; // reset state
    vecs[1]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 4'hF, 1'b1, 1'b0}; // IDLE->BLANK
    vecs[2]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 4'hF, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 4'hE, 1'b1, 1'b0}; // SHOW d0
    vecs[4]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 4'hE, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 4'hE, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 4'hE, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd1, 4'hF, 1'b1, 1'b0}; // BLANK d1
    vecs[8]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 2'd1, 4'hF, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 4'hD, 1'b0, 1'b0}; // SHOW d1, dp lit
    vecs[10] = '{1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 4'hD, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'b1101, 4'b0010, 2'd2, 4'hF, 1'b1, 1'b0}; // early end
    vecs[12] = '{1'b0, 1'b1, 4'b1101, 4'b0010, 2'd2, 4'hF, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2, 4'hF, 1'b1, 1'b0}; // none -> IDLE
    vecs[14] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 4'hF, 1'b1, 1'b0}; // single digit 3
    vecs[15] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 4'hF, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 4'h7, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 4'h7, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 4'h7, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 4'h7, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 4'hF, 1'b1, 1'b1}; // wrap pulse
    vecs[21] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 4'hF, 1'b1, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst; enable = vecs[i].en; digits_en = vecs[i].de; dp_in = vecs[i].dp;
      tick();
      check_outputs(vecs[i].e_sel, vecs[i].e_an, vecs[i].e_dpn, vecs[i].e_fd,
                    $sformatf("vec%0d", i));
    end

    // Full scan: frame_done spacing and anode/sel agreement over 60 clocks.
    enable = 1'b1; digits_en = 4'hF; dp_in = 4'h0;
    do_reset();
    bad_anode = 0;
    for (cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (frame_done) fd_cycles.push_back(cyc);
      if (anode != 4'hF && anode != (4'hF & ~(4'(1) << sel))) bad_anode = 1;
    end
    check("full.anode_matches_sel", 32'(bad_anode), 32'd0);
    check("full.fd_count", 32'(fd_cycles.size()), 32'd2);
    if (fd_cycles.size() >= 2)
      check("full.fd_period", 32'(fd_cycles[1] - fd_cycles[0]), 32'd24);

    // Skipping: digits 1 and 3 never lit, frame_done every 12 clocks.
    digits_en = 4'b0101;
    do_reset();
    fd_cycles.delete();
    bad_anode = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (frame_done) fd_cycles.push_back(cyc);
      if (anode == 4'hD || anode == 4'h7 || sel == 2'd1 || sel == 2'd3) bad_anode = 1;
    end
    check("skip.no_disabled_digit", 32'(bad_anode), 32'd0);
    check("skip.fd_count", 32'(fd_cycles.size()), 32'd3);
    if (fd_cycles.size() >= 2)
      check("skip.fd_period", 32'(fd_cycles[1] - fd_cycles[0]), 32'd12);

    // Disable mid-SHOW on digit 1, then re-enable with a new lowest digit.
    digits_en = 4'hF;
    do_reset();
    wait_anode(4'hD, 40, "dis");
    tick();                                   // second show cycle of digit 1
    enable = 1'b0;
    tick();
    check_outputs(2'd1, 4'hF, 1'b1, 1'b0, "dis.off");
    tick();
    check_outputs(2'd1, 4'hF, 1'b1, 1'b0, "dis.idle_hold");
    enable = 1'b1; digits_en = 4'b1100;
    tick();
    check_outputs(2'd2, 4'hF, 1'b1, 1'b0, "dis.reenable_blank");
    tick(); tick();
    check_outputs(2'd2, 4'hB, 1'b1, 1'b0, "dis.reenable_show");

    // Reset mid-BLANK, then resume from IDLE.
    digits_en = 4'hF;
    wait_anode(4'hF, 40, "rstb");
    rst = 1'b1;
    tick();
    check_outputs(2'd0, 4'hF, 1'b1, 1'b0, "rstb.reset");
    rst = 1'b0;
    tick(); tick();
    check_outputs(2'd0, 4'hF, 1'b1, 1'b0, "rstb.blank");
    tick();
    check_outputs(2'd0, 4'hE, 1'b1, 1'b0, "rstb.show");

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 19) == 0) digits_en = 4'($urandom_range(0, 15));
      dp_in  = 4'($urandom_range(0, 15));
      tick();
      check_outputs(2'(m_sel), model_anode(), m_dpn, m_fd, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
